mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Arbitrates the pipeline's instruction-fetch port and data-memory port onto a single shared memory bus with one outstanding transaction. It sits between the datapath (fetch address `pcF`, memory-stage `aluoutM`/`writedataM`) and the SoC memory bus. It returns per-port completion pulses and stall requests that the hazard unit folds into `stallF` and the memory-stage stall.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byte strobes are DW/8 wide)
- `TIMEOUT`, 255, maximum BUSY cycles without `bus_ack`; used only with the timeout feature

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `inst_req` in 1: fetch request; held with stable address until `inst_ok`.
- `inst_addr` in AW: fetch address.
- `inst_rdata` out DW: fetched word; valid only while `inst_ok` = 1.
- `inst_ok` out 1: one-cycle completion pulse for the fetch port.
- `data_req` in 1: load/store request; held with stable fields until `data_ok`.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_wstrb` in DW/8: byte enables for stores.
- `data_addr` in AW: data address.
- `data_wdata` in DW: store data.
- `data_rdata` out DW: load data; valid only while `data_ok` = 1.
- `data_ok` out 1: one-cycle completion pulse for the data port.
- `stall_inst` out 1: `inst_req & ~inst_ok`.
- `stall_data` out 1: `data_req & ~data_ok`.
- `bus_req` out 1: bus request; held high until `bus_ack`.
- `bus_wr` out 1: bus write flag.
- `bus_wstrb` out DW/8: bus byte enables; 0 for reads.
- `bus_addr` out AW: bus address.
- `bus_wdata` out DW: bus write data.
- `bus_rdata` in DW: read data; valid in the `bus_ack` cycle.
- `bus_ack` in 1: transaction complete.
- `err` out 1: timeout completion flag; pulses together with `*_ok`.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE:
  - If `data_req` is high, grant data; otherwise, if `inst_req` is high, grant inst. Data has fixed priority because it belongs to the older instruction.
  - On a grant: go to BUSY, latch the granted port's address, write flag, strobes and wdata into bus registers, and record the grant owner.
  - With no request, stay in IDLE.
- BUSY:
  - `bus_req` = 1 and all bus fields are held stable.
  - On `bus_ack`: latch `bus_rdata` into the owner's rdata register and go to DONE.
- DONE:
  - The owner's `*_ok` = 1 for exactly this cycle; the other port's ok stays 0.
  - Requests are ignored in this state; next state is IDLE.
  - The requester deasserts or replaces its request at the next edge, so no duplicate is issued.
- Stores also complete through DONE. Their rdata is 0.
- A request arriving while the other port is in service waits. Its stall output stays high for the whole wait.
- `bus_ack` seen in IDLE or DONE is ignored.
- Async reset mid-transaction: the state goes to IDLE and every output drops to 0 immediately. The bus slave tolerates an abandoned request.

## Timing
- Reset value: every output is 0 and the state is IDLE.
- Outputs are registered, except `stall_inst`/`stall_data`, which are combinational from the requests and the registered oks.
- For a request first seen in IDLE at cycle 0:
  - `bus_req` goes high in cycle 1.
  - `bus_ack` arrives in cycle n ≥ 1.
  - `*_ok` and rdata are valid in cycle n+1.
  - The state is IDLE again in cycle n+2.
  - Minimum cost is 3 cycles per access.
- Back-to-back accesses (a pipeline load following a fetch) alternate through IDLE; no cycle overlaps two transactions.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entering BUSY and increments each BUSY cycle without `bus_ack`.
  - When it reaches TIMEOUT, the arbiter goes to DONE with `err` = 1, owner rdata = 0 and `bus_req` dropped.
  - A simultaneous `bus_ack` takes precedence over the timeout, giving normal completion with `err` = 0.
- Undefined: there is no counter, BUSY waits indefinitely, and `err` is tied to 0.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - the owner enum (INST/DATA);
  - default width constants.
- Single module, no sub-modules. The timeout counter is inline under the macro.

## Test plan
- Single fetch: `inst_req` = 1, `inst_addr` = 0xBFC00000, ack 1 cycle after `bus_req` with `bus_rdata` = 0x24080001 -> `bus_addr` = 0xBFC00000, `bus_wr` = 0, then `inst_ok` = 1 with `inst_rdata` = 0x24080001 in cycle 3, and `stall_inst` low from that cycle.
- Simultaneous requests: `inst_req` and `data_req` (load 0x80000010) both rise in cycle 0 -> data is served first and `data_ok` pulses; `stall_inst` stays high until the fetch's `inst_ok` pulses 3 cycles later.
- Store: `data_wr` = 1, `data_wstrb` = 4'b0011, `data_wdata` = 0x0000BEEF, 4-cycle ack delay -> bus fields stable for all BUSY cycles, then `data_ok` pulses once with `data_rdata` = 0.
- Reset mid-BUSY: assert `rst` low while `bus_req` = 1 -> all outputs are 0 asynchronously, and after release the first request restarts cleanly from IDLE.
- Timeout (macro on, TIMEOUT = 8): no ack -> `data_ok` = 1 and `err` = 1 after 8 BUSY cycles with rdata = 0; a late `bus_ack` in IDLE produces no further ok.
- Timeout edge: `bus_ack` in exactly the TIMEOUT cycle -> normal completion with `err` = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } arb_owner_t;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one bus, one outstanding access, data has fixed priority; ok pulses one cycle after bus_ack.
// Waiting ports see stall until their ok; optional bus timeout under MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ok,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ok,
  output logic            stall_inst,
  output logic            stall_data,
  output logic            bus_req,
  output logic            bus_wr,
  output logic [DW/8-1:0] bus_wstrb,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack,
  output logic            err
);

  arb_state_t state;
  arb_owner_t owner;
  logic       tmo_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  // Hit on the TIMEOUT-th BUSY cycle without an ack; the ack check below wins a tie.
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state != ST_BUSY) begin
      tmo_cnt <= '0;
    end else if (!bus_ack) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  // The timeout length only matters when the counter is built in.
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign stall_inst = inst_req & ~inst_ok;
  assign stall_data = data_req & ~data_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_INST;
      inst_rdata <= '0;
      inst_ok    <= 1'b0;
      data_rdata <= '0;
      data_ok    <= 1'b0;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (data_req) begin
            state     <= ST_BUSY;
            owner     <= OWN_DATA;
            bus_req   <= 1'b1;
            bus_wr    <= data_wr;
            bus_wstrb <= data_wr ? data_wstrb : '0;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
          end else if (inst_req) begin
            state     <= ST_BUSY;
            owner     <= OWN_INST;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            if (owner == OWN_DATA) begin
              data_ok    <= 1'b1;
              data_rdata <= bus_wr ? '0 : bus_rdata;
            end else begin
              inst_ok    <= 1'b1;
              inst_rdata <= bus_rdata;
            end
          end else if (tmo_hit) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            err     <= 1'b1;
            if (owner == OWN_DATA) begin
              data_ok    <= 1'b1;
              data_rdata <= '0;
            end else begin
              inst_ok    <= 1'b1;
              inst_rdata <= '0;
            end
          end
        end
        ST_DONE: begin
          // Requests are still the old ones here; look again only from IDLE.
          state      <= ST_IDLE;
          inst_rdata <= '0;
          data_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
